// File: rtl/dnn_result_argmax.sv
// Result capture and argmax stage behind the DNN engine: snapshots all class
// scores on engine completion, scans them for the winner, and serves indexed reads.
module dnn_result_argmax #(
    parameter int DATA_WIDTH  = 13,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_WIDTH   = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clear,
    input  logic                              eng_done,
    input  logic [NUM_CLASSES*DATA_WIDTH-1:0] scores_in,
    output logic                              busy,
    output logic                              class_valid,
    output logic [IDX_WIDTH-1:0]              class_idx,
    output logic signed [DATA_WIDTH-1:0]      class_score,
    input  logic                              rd_en,
    input  logic [IDX_WIDTH-1:0]              rd_idx,
    output logic                              rd_valid,
    output logic signed [DATA_WIDTH-1:0]      rd_data,
    output logic                              rd_err
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam int unsigned NC = NUM_CLASSES;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

    state_t                       state;
    logic signed [DATA_WIDTH-1:0] score_q [NUM_CLASSES];
    logic signed [DATA_WIDTH-1:0] best_score;
    logic [IDX_WIDTH-1:0]         best_idx;
    logic [IDX_WIDTH-1:0]         cnt;
    logic                         done_q;

    logic                         capture;
    logic signed [DATA_WIDTH-1:0] cand;
    logic                         win;

    assign capture = eng_done & ~done_q;
    assign cand    = score_q[cnt];
    // Strict signed greater-than: ties keep the lower index.
    assign win     = cand > best_score;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            done_q      <= 1'b0;
            best_score  <= '0;
            best_idx    <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            class_valid <= 1'b0;
            class_idx   <= '0;
            class_score <= '0;
            for (int unsigned k = 0; k < NC; k++) begin
                score_q[k] <= '0;
            end
        end else if (clear) begin
            // History cleared so a still-high eng_done recaptures next cycle.
            state       <= IDLE;
            done_q      <= 1'b0;
            best_score  <= '0;
            best_idx    <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            class_valid <= 1'b0;
            class_idx   <= '0;
            class_score <= '0;
            for (int unsigned k = 0; k < NC; k++) begin
                score_q[k] <= '0;
            end
        end else begin
            done_q <= eng_done;
            if (capture) begin
                for (int unsigned k = 0; k < NC; k++) begin
                    score_q[k] <= scores_in[k*DATA_WIDTH +: DATA_WIDTH];
                end
                best_score  <= scores_in[DATA_WIDTH-1:0];
                best_idx    <= '0;
                cnt         <= IDX_WIDTH'(1);
                busy        <= 1'b1;
                class_valid <= 1'b0;
                class_idx   <= '0;
                class_score <= '0;
                state       <= SCAN;
            end else begin
                case (state)
                    SCAN: begin
                        if (win) begin
                            best_score <= cand;
                            best_idx   <= cnt;
                        end
                        if (cnt == LAST_IDX) begin
                            // Final comparison folds straight into the registered result.
                            state       <= DONE;
                            busy        <= 1'b0;
                            class_valid <= 1'b1;
                            class_idx   <= win ? cnt : best_idx;
                            class_score <= win ? cand : best_score;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                if (32'(rd_idx) >= NC) begin
                    rd_err  <= 1'b1;
                    rd_data <= '0;
                end else begin
                    rd_err  <= 1'b0;
                    rd_data <= score_q[rd_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_dnn_result_argmax.sv
// Directed bench for dnn_result_argmax: default and 16-class instances.
module tb_dnn_result_argmax;

    logic               clk = 1'b0;
    logic               rst, clear;
    logic               eng_done, rd_en;
    logic [3:0]         rd_idx;
    logic [129:0]       scores_in;
    logic               busy, class_valid, rd_valid, rd_err;
    logic [3:0]         class_idx;
    logic signed [12:0] class_score, rd_data;

    logic               eng_done2, rd_en2;
    logic [3:0]         rd_idx2;
    logic [255:0]       scores2;
    logic               busy2, class_valid2, rd_valid2, rd_err2;
    logic [3:0]         class_idx2;
    logic signed [15:0] class_score2, rd_data2;

    int n_checks = 0;
    int n_fail   = 0;
    int exp10 [10];
    int exp16 [16];
    int n;

    always #5 clk = ~clk;

    dnn_result_argmax dut (
        .clk(clk), .rst(rst), .clear(clear), .eng_done(eng_done), .scores_in(scores_in),
        .busy(busy), .class_valid(class_valid), .class_idx(class_idx), .class_score(class_score),
        .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err)
    );

    dnn_result_argmax #(.DATA_WIDTH(16), .NUM_CLASSES(16), .IDX_WIDTH(4)) dut16 (
        .clk(clk), .rst(rst), .clear(clear), .eng_done(eng_done2), .scores_in(scores2),
        .busy(busy2), .class_valid(class_valid2), .class_idx(class_idx2), .class_score(class_score2),
        .rd_en(rd_en2), .rd_idx(rd_idx2), .rd_valid(rd_valid2), .rd_data(rd_data2), .rd_err(rd_err2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(expv));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load10();
        for (int k = 0; k < 10; k++) scores_in[k*13 +: 13] = 13'(exp10[k]);
    endtask

    task automatic load16();
        for (int k = 0; k < 16; k++) scores2[k*16 +: 16] = 16'(exp16[k]);
    endtask

    // Counts cycles after the capture edge until class_valid, bounded.
    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!class_valid && cycles < 64) begin
            step();
            cycles++;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_valid"}, 32'(class_valid), 0);
        check({tag, "_idx"}, 32'(class_idx), 0);
        check({tag, "_score"}, class_score, 0);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; eng_done = 1'b0; rd_en = 1'b0; rd_idx = '0; scores_in = '0;
        eng_done2 = 1'b0; rd_en2 = 1'b0; rd_idx2 = '0; scores2 = '0;
        step(); step();
        check_idle_outputs("reset");
        check("reset_rd_valid", 32'(rd_valid), 0);
        check("reset_rd_data", rd_data, 0);
        check("reset_rd_err", 32'(rd_err), 0);
        #2 rst = 1'b0;
        step();

        // Basic scan: winner at index 1, busy for exactly 9 cycles.
        exp10 = '{-5, 100, 3, 4, 5, 6, -7, 8, 99, 7};
        load10();
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        for (int i = 0; i < 9; i++) begin
            check("s1_busy", 32'(busy), 1);
            check("s1_valid_low", 32'(class_valid), 0);
            step();
        end
        check("s1_busy_end", 32'(busy), 0);
        check("s1_valid", 32'(class_valid), 1);
        check("s1_idx", 32'(class_idx), 1);
        check("s1_score", class_score, 100);

        // Back-to-back readout of every class.
        rd_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rd_idx = 4'(i);
            step();
            check("rd_valid", 32'(rd_valid), 1);
            check("rd_err", 32'(rd_err), 0);
            check("rd_data", rd_data, exp10[i]);
        end
        rd_en = 1'b0;
        step();
        check("rd_valid_drop", 32'(rd_valid), 0);
        check("rd_data_hold", rd_data, 7);
        rd_en = 1'b1; rd_idx = 4'd12;
        step();
        rd_en = 1'b0;
        check("rd_oor_valid", 32'(rd_valid), 1);
        check("rd_oor_err", 32'(rd_err), 1);
        check("rd_oor_data", rd_data, 0);

        // Tie at 3 and 7; read in the capture cycle sees the old snapshot.
        exp10 = '{0, 0, 0, 200, 0, 0, 0, 200, 0, 0};
        load10();
        eng_done = 1'b1; rd_en = 1'b1; rd_idx = 4'd1;
        step();
        eng_done = 1'b0; rd_en = 1'b0;
        check("cap_read_old", rd_data, 100);
        wait_valid(n);
        check("tie_latency", n, 9);
        check("tie_idx", 32'(class_idx), 3);
        check("tie_score", class_score, 200);

        // All scores at the signed minimum.
        exp10 = '{-4096, -4096, -4096, -4096, -4096, -4096, -4096, -4096, -4096, -4096};
        load10();
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        wait_valid(n);
        check("min_latency", n, 9);
        check("min_idx", 32'(class_idx), 0);
        check("min_score", class_score, -4096);

        // Restart mid-scan with a new snapshot (winner 8).
        exp10 = '{-5, 100, 3, 4, 5, 6, -7, 8, 99, 7};
        load10();
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        for (int i = 0; i < 4; i++) step();
        exp10 = '{1, 40, 1, 1, 1, 1, 1, 1, 50, 1};
        load10();
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        check("rs_valid_low", 32'(class_valid), 0);
        wait_valid(n);
        check("rs_latency", n, 9);
        check("rs_idx", 32'(class_idx), 8);
        check("rs_score", class_score, 50);

        // eng_done held high: one capture only.
        exp10 = '{0, 0, 0, 200, 0, 0, 0, 200, 0, 0};
        load10();
        eng_done = 1'b1;
        step();
        wait_valid(n);
        check("hold_latency", n, 9);
        for (int i = 0; i < 20; i++) begin
            step();
            check("hold_busy", 32'(busy), 0);
            check("hold_valid", 32'(class_valid), 1);
        end

        // clear during scan, then recapture from the still-high level.
        eng_done = 1'b0;
        step();
        eng_done = 1'b1;
        step();
        for (int i = 0; i < 4; i++) step();
        check("pre_clear_busy", 32'(busy), 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_idle_outputs("clear");
        step();
        check("recap_busy", 32'(busy), 1);
        wait_valid(n);
        check("recap_latency", n, 9);
        check("recap_idx", 32'(class_idx), 3);
        eng_done = 1'b0;

        // Asynchronous reset mid-scan.
        exp10 = '{-5, 100, 3, 4, 5, 6, -7, 8, 99, 7};
        load10();
        eng_done = 1'b1;
        step();
        eng_done = 1'b0; rd_en = 1'b1; rd_idx = 4'd1;
        step();
        rd_en = 1'b0;
        step(); step();
        #2 rst = 1'b1;
        #1;
        check_idle_outputs("arst");
        check("arst_rd_valid", 32'(rd_valid), 0);
        check("arst_rd_data", rd_data, 0);
        check("arst_rd_err", 32'(rd_err), 0);
        #2 rst = 1'b0;
        step();

        // 16-class instance: winner 13, 15-cycle scan, top index readable.
        for (int k = 0; k < 16; k++) exp16[k] = k * 3 - 20;
        exp16[13] = 500;
        load16();
        eng_done2 = 1'b1;
        step();
        eng_done2 = 1'b0;
        n = 0;
        while (!class_valid2 && n < 64) begin
            step();
            n++;
        end
        check("n16_latency", n, 15);
        check("n16_idx", 32'(class_idx2), 13);
        check("n16_score", class_score2, 500);
        rd_en2 = 1'b1; rd_idx2 = 4'd15;
        step();
        rd_en2 = 1'b0;
        check("n16_rd_valid", 32'(rd_valid2), 1);
        check("n16_rd_err", 32'(rd_err2), 0);
        check("n16_rd_data", rd_data2, exp16[15]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
